frame_scheduler: RTL

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_scheduler_pkg.sv | 16 +
 rtl/frame_tick_gen.sv | 29 ++
 rtl/frame_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: sequence state encoding and
// frame-period constants for a 50 MHz clock.
package frame_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ERASE  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_DRAW   = 2'd3
   } state_e;

   localparam int unsigned FPS60_CYCLES = 833333;
   localparam int unsigned FPS30_CYCLES = 1666667;
   localparam int          FRAME_NUM_W  = 16;

endpackage

// File: rtl/frame_tick_gen.sv
// Display-frame down-counter; emits a one-cycle frame_tick when the count
// reaches zero while enabled, then reloads on the following cycle.
module frame_tick_gen
   import frame_scheduler_pkg::*;
#(
   parameter int unsigned CYCLES_PER_FRAME = FPS60_CYCLES,
   parameter int          CNT_W            = 20
) (
   input  logic clk,
   input  logic resetn,
   input  logic enable,
   output logic frame_tick
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES_PER_FRAME - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!resetn)
         cnt <= RELOAD;
      else if (enable)
         cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
   end

   // Gated by resetn so no tick escapes while reset is being applied.
   assign frame_tick = resetn && enable && (cnt == '0);

endmodule

// File: rtl/frame_scheduler.sv
// Game-loop scheduler: divides display frames into game ticks and sequences
// the erase -> update -> draw phases, flagging ticks that arrive while busy.
module frame_scheduler
   import frame_scheduler_pkg::*;
#(
   parameter int unsigned CYCLES_PER_FRAME = FPS60_CYCLES,
   parameter int          CNT_W            = 20
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   enable,
   input  logic [3:0]             skip_count,
   input  logic                   erase_done,
   input  logic                   update_done,
   input  logic                   draw_done,
   input  logic                   clear_overrun,
   output logic                   erase_start,
   output logic                   update_start,
   output logic                   draw_start,
   output logic                   frame_tick,
   output logic                   busy,
   output logic                   overrun,
   output logic [FRAME_NUM_W-1:0] frame_number
);

   state_e     state, state_nx;
   logic       tick;
   logic       game_tick;
   logic       seq_done;
   logic [3:0] skip_cnt;
   logic       erase_q, update_q, draw_q;

   frame_tick_gen #(
      .CYCLES_PER_FRAME(CYCLES_PER_FRAME),
      .CNT_W           (CNT_W)
   ) u_tick (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .frame_tick(tick)
   );

   assign frame_tick = tick;
   assign game_tick  = tick && (skip_cnt == 4'd0);

   always_ff @(posedge clk) begin
      if (!resetn)
         skip_cnt <= 4'd0;
      else if (tick)
         skip_cnt <= (skip_cnt == 4'd0) ? skip_count : skip_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      seq_done = 1'b0;
      case (state)
         ST_IDLE:   if (game_tick)   state_nx = ST_ERASE;
         ST_ERASE:  if (erase_done)  state_nx = ST_UPDATE;
         ST_UPDATE: if (update_done) state_nx = ST_DRAW;
         ST_DRAW: begin
            if (draw_done) begin
               state_nx = ST_IDLE;
               seq_done = 1'b1;
            end
         end
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Start pulses are registered on state entry so they land in the first
   // cycle of the new state.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         erase_q  <= 1'b0;
         update_q <= 1'b0;
         draw_q   <= 1'b0;
      end else begin
         erase_q  <= (state_nx == ST_ERASE)  && (state != ST_ERASE);
         update_q <= (state_nx == ST_UPDATE) && (state != ST_UPDATE);
         draw_q   <= (state_nx == ST_DRAW)   && (state != ST_DRAW);
      end
   end

   assign erase_start  = resetn && erase_q;
   assign update_start = resetn && update_q;
   assign draw_start   = resetn && draw_q;
   assign busy         = resetn && (state != ST_IDLE);

   // A set in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (!resetn)
         overrun <= 1'b0;
      else if (game_tick && (state != ST_IDLE))
         overrun <= 1'b1;
      else if (clear_overrun)
         overrun <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         frame_number <= '0;
      else if (seq_done)
         frame_number <= frame_number + 1'b1;
   end

endmodule
